// File: rtl/cordic_pipe_param.sv
// Fully pipelined two's-complement CORDIC: per-sample rotation/vectoring mode,
// quadrant pre-rotation, gain compensation, valid/stall pipeline and sideband tag.
module cordic_pipe_param #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned STAGES = 12,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    in_valid,
  input  logic                    in_mode,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic signed [WIDTH-1:0] in_z,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  output logic                    out_mode,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic signed [WIDTH-1:0] out_z,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned PW = XW + FRAC + 1;
  // pi/4 in Q40; every angle constant is derived from Q40 values and rounded to FRAC
  localparam longint PI_4_Q40 = 64'sd863554413089;

  function automatic longint q40_round(input longint q);
    return (q + (64'sd1 <<< (39 - FRAC))) >>> (40 - FRAC);
  endfunction

  // atan(2^-i) in Q40 from the alternating power series (exact shifts of 2^40)
  function automatic longint atan_q40(input int i);
    longint acc;
    int     e;
    if (i == 0) return PI_4_Q40;
    acc = 64'sd0;
    for (int k = 0; k < 40; k++) begin
      e = 40 - i * (2 * k + 1);
      if (e >= 0) begin
        if (k % 2 == 0) acc = acc + (64'sd1 <<< e) / longint'(2 * k + 1);
        else            acc = acc - (64'sd1 <<< e) / longint'(2 * k + 1);
      end
    end
    return acc;
  endfunction

  function automatic logic [STAGES*WIDTH-1:0] atan_tbl();
    logic [STAGES*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < STAGES; i++) r[i*WIDTH +: WIDTH] = WIDTH'(q40_round(atan_q40(i)));
    return r;
  endfunction

  localparam logic signed [WIDTH-1:0] PI2 = WIDTH'(q40_round(2 * PI_4_Q40));
  localparam logic signed [PW-1:0]    K_P =
    PW'(((64'sd6072529 <<< FRAC) + 64'sd5000000) / 64'sd10000000);
  localparam logic [STAGES*WIDTH-1:0] ATAN_TBL = atan_tbl();

  // Gain compensation: multiply by K, truncate FRAC bits, saturate to WIDTH
  function automatic logic signed [WIDTH-1:0] scale_sat(input logic signed [XW-1:0] v);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] s;
    p = PW'(v) * K_P;
    s = p >>> FRAC;
    if (s[PW-1:WIDTH-1] == {(PW-WIDTH+1){s[PW-1]}}) return s[WIDTH-1:0];
    return {s[PW-1], {(WIDTH-1){~s[PW-1]}}};
  endfunction

  // Index 0 is the pre-rotation register, index i+1 is iteration stage i
  logic                    v_q [STAGES+1];
  logic                    m_q [STAGES+1];
  logic [TAG_W-1:0]        t_q [STAGES+1];
  logic signed [XW-1:0]    x_q [STAGES+1];
  logic signed [XW-1:0]    y_q [STAGES+1];
  logic signed [WIDTH-1:0] z_q [STAGES+1];
  logic signed [XW-1:0]    x_d [STAGES+1];
  logic signed [XW-1:0]    y_d [STAGES+1];
  logic signed [WIDTH-1:0] z_d [STAGES+1];

  logic signed [XW-1:0]    xe, ye, xs, ys;
  logic signed [WIDTH-1:0] at;
  logic                    dp;

  always_comb begin
    xe = XW'(in_x);
    ye = XW'(in_y);
    xs = '0;
    ys = '0;
    at = '0;
    dp = 1'b0;
    x_d[0] = xe;
    y_d[0] = ye;
    z_d[0] = in_z;
    if (!in_mode) begin
      if (in_z > PI2) begin
        x_d[0] = -ye; y_d[0] = xe;  z_d[0] = in_z - PI2;
      end else if (in_z < -PI2) begin
        x_d[0] = ye;  y_d[0] = -xe; z_d[0] = in_z + PI2;
      end
    end else if (in_x[WIDTH-1]) begin
      if (!in_y[WIDTH-1]) begin
        x_d[0] = ye;  y_d[0] = -xe; z_d[0] = in_z + PI2;
      end else begin
        x_d[0] = -ye; y_d[0] = xe;  z_d[0] = in_z - PI2;
      end
    end
    // Micro-rotations: rotation drives z to 0, vectoring drives y to 0
    for (int i = 0; i < STAGES; i++) begin
      xs = x_q[i] >>> i;
      ys = y_q[i] >>> i;
      at = ATAN_TBL[i*WIDTH +: WIDTH];
      dp = m_q[i] ? y_q[i][XW-1] : ~z_q[i][WIDTH-1];
      if (dp) begin
        x_d[i+1] = x_q[i] - ys;
        y_d[i+1] = y_q[i] + xs;
        z_d[i+1] = z_q[i] - at;
      end else begin
        x_d[i+1] = x_q[i] + ys;
        y_d[i+1] = y_q[i] - xs;
        z_d[i+1] = z_q[i] + at;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q       <= '{default: 1'b0};
      m_q       <= '{default: 1'b0};
      t_q       <= '{default: '0};
      x_q       <= '{default: '0};
      y_q       <= '{default: '0};
      z_q       <= '{default: '0};
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (!stall) begin
      v_q[0] <= in_valid;
      m_q[0] <= in_mode;
      t_q[0] <= in_tag;
      for (int i = 0; i < STAGES; i++) begin
        v_q[i+1] <= v_q[i];
        m_q[i+1] <= m_q[i];
        t_q[i+1] <= t_q[i];
      end
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      out_valid <= v_q[STAGES];
      out_mode  <= m_q[STAGES];
      out_tag   <= t_q[STAGES];
      out_x     <= scale_sat(x_q[STAGES]);
      out_y     <= scale_sat(y_q[STAGES]);
      out_z     <= z_q[STAGES];
    end
  end

endmodule

// File: tb/tb_cordic_pipe_param.sv
// Self-checking bench for cordic_pipe_param: floating-point reference model,
// in-order scoreboard with latency, stall-freeze and mid-stream reset checks.
module tb_cordic_pipe_param;

  logic               clock = 1'b0;
  logic               reset, stall, in_valid, in_mode;
  logic signed [15:0] in_x, in_y, in_z;
  logic [3:0]         in_tag;
  logic               out_valid, out_mode;
  logic signed [15:0] out_x, out_y, out_z;
  logic [3:0]         out_tag;

  cordic_pipe_param #(.WIDTH(16), .FRAC(8), .STAGES(12), .TAG_W(4)) dut (
    .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
    .out_valid(out_valid), .out_mode(out_mode), .out_x(out_x), .out_y(out_y),
    .out_z(out_z), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       mode;
    logic [3:0] tag;
    real        ex, ey, ez;
    int         txy, tz;
    int         c0;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     n_assert = 0;
  int     n_fail = 0;
  int     live_edges = 0;
  logic   last_live = 1'b0;
  longint snap;

  // Count only edges that advance the pipeline
  always @(posedge clock) begin
    if (reset && !stall) live_edges <= live_edges + 1;
    last_live <= reset && !stall;
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input real expv, input int tol);
    real  d;
    logic ok;
    d = $itor(obs) - expv;
    if (d < 0.0) d = -d;
    ok = (d <= $itor(tol));
    n_assert++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0.2f +/- %0d", tag, obs, expv, tol);
    end
  endtask

  // Drive one sample; it is scored only if this edge will accept it
  task automatic put(input logic m, input int x, input int y, input int z,
                     input logic [3:0] t, input int txy, input int tz);
    exp_t e;
    real  a;
    in_valid = 1'b1; in_mode = m; in_tag = t;
    in_x = 16'(x); in_y = 16'(y); in_z = 16'(z);
    e.mode = m; e.tag = t; e.txy = txy; e.tz = tz; e.c0 = live_edges;
    if (!m) begin
      a    = $itor(z) / 256.0;
      e.ex = $itor(x) * $cos(a) - $itor(y) * $sin(a);
      e.ey = $itor(x) * $sin(a) + $itor(y) * $cos(a);
      e.ez = 0.0;
    end else begin
      e.ex = $sqrt($itor(x) * $itor(x) + $itor(y) * $itor(y));
      e.ey = 0.0;
      e.ez = 256.0 * $atan2($itor(y), $itor(x)) + $itor(z);
    end
    if (!stall) q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 60) begin
      @(negedge clock);
      in_valid = 1'b0;
      k++;
    end
    chk("drain_empty", longint'(q.size()), 0);
  endtask

  always @(negedge clock) begin
    if (reset && last_live && out_valid) begin
      chk("result_expected", longint'(q.size() > 0), 1);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("latency", longint'(live_edges - mon_e.c0), 14);
        chk("out_mode", longint'(out_mode), longint'(mon_e.mode));
        chk("out_tag", longint'(out_tag), longint'(mon_e.tag));
        chk_near("out_x", int'(out_x), mon_e.ex, mon_e.txy);
        chk_near("out_y", int'(out_y), mon_e.ey, mon_e.txy);
        chk_near("out_z", int'(out_z), mon_e.ez, mon_e.tz);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   x, y, z;
    logic m;
    reset = 1'b0; stall = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_x = '0; in_y = '0; in_z = '0; in_tag = '0;
    repeat (2) @(negedge clock);
    chk("reset_state", longint'({out_valid, out_mode, out_tag, out_x, out_y, out_z}), 0);
    reset = 1'b1;

    // Directed cases
    @(negedge clock); put(1'b0, 256, 0, 201, 4'd1, 3, 2);   drain();
    @(negedge clock); put(1'b0, 256, 0, 804, 4'd2, 3, 2);   drain();
    @(negedge clock); put(1'b1, 0, 256, 0, 4'd3, 3, 2);     drain();
    @(negedge clock); put(1'b1, -256, -256, 0, 4'd4, 3, 2); drain();

    // Mixed-mode stream with stalls at samples 7 and 17
    for (int s = 0; s < 20; s++) begin
      m = 1'(s % 3 == 1 || s % 5 == 2);
      x = int'($urandom_range(400)) - 200;
      y = int'($urandom_range(400)) - 200;
      if (x > -100 && x < 100 && y > -100 && y < 100) x = 180;
      if (m && x < 0 && y > -40 && y < 40) y = 100;
      z = m ? int'($urandom_range(200)) - 100 : int'($urandom_range(1400)) - 700;
      @(negedge clock);
      if (s == 7 || s == 17) begin
        stall = 1'b1;
        put(m, x, y, z, 4'(s % 16), 4, 3);
        snap = longint'({out_valid, out_mode, out_tag, out_x, out_y, out_z});
        repeat ((s == 7) ? 3 : 2) begin
          @(negedge clock);
          chk("stall_freeze", longint'({out_valid, out_mode, out_tag, out_x, out_y, out_z}), snap);
        end
        stall = 1'b0;
      end
      put(m, x, y, z, 4'(s % 16), 4, 3);
    end
    drain();

    // Mid-stream reset with five samples in flight
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      put(1'(s % 2), 200 - 30 * s, 50 + 20 * s, 100, 4'(s + 10), 3, 2);
    end
    @(negedge clock);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk("reset_async", longint'({out_valid, out_mode, out_tag, out_x, out_y, out_z}), 0);
    q.delete();
    @(negedge clock);
    reset = 1'b1;
    idle(20);
    chk("no_stale_valid", longint'(out_valid), 0);
    @(negedge clock); put(1'b1, 150, -120, 30, 4'd9, 3, 2);
    drain();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
